// File: rtl/game_session_if.sv
// Signal bundle between the game session controller and its neighbours:
// collision/level/score sources in, gameplay gates and status out.
interface game_session_if;
  logic       i_Start;
  logic       i_Has_Collided;
  logic       i_Level_Up;
  logic [6:0] i_Score;
  logic       o_Game_Active;
  logic       o_Frog_Respawn;
  logic [1:0] o_Lives;
  logic       o_Game_Over;
  logic [6:0] o_High_Score;

  modport master (
    output i_Start, i_Has_Collided, i_Level_Up, i_Score,
    input  o_Game_Active, o_Frog_Respawn, o_Lives, o_Game_Over, o_High_Score
  );

  modport slave (
    input  i_Start, i_Has_Collided, i_Level_Up, i_Score,
    output o_Game_Active, o_Frog_Respawn, o_Lives, o_Game_Over, o_High_Score
  );
endinterface

// File: rtl/game_session_controller.sv
// Session FSM: lives, death freeze, guarded restart and session high score.
// Start must be seen low before it is honoured, so a held switch never restarts.
module game_session_controller #(
  parameter int c_LIVES_INI           = 3,
  parameter int c_LIVES_MAX           = 3,
  parameter int c_DEATH_FREEZE_CYCLES = 25_000_000,
  parameter int c_SCORE_MAX           = 99
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  game_session_if.slave  bus
);
  localparam int CNT_W = (c_DEATH_FREEZE_CYCLES > 1) ? $clog2(c_DEATH_FREEZE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(c_DEATH_FREEZE_CYCLES - 1);
  localparam logic [1:0]       LIVES_INI = 2'(c_LIVES_INI);
  localparam logic [1:0]       LIVES_MAX = 2'(c_LIVES_MAX);
  localparam logic [6:0]       SCORE_MAX = 7'(c_SCORE_MAX);

  typedef enum logic [1:0] {IDLE, RUNNING, DYING, GAME_OVER} state_t;

  state_t           state, state_nxt;
  logic [1:0]       lives, lives_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             armed, armed_nxt;
  logic             respawn, respawn_nxt;
  logic             coll_q;
  logic [6:0]       high, clamped;
  logic             coll_edge;

  assign coll_edge = bus.i_Has_Collided & ~coll_q;
  assign clamped   = (bus.i_Score > SCORE_MAX) ? SCORE_MAX : bus.i_Score;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= IDLE;
      lives   <= LIVES_INI;
      cnt     <= '0;
      armed   <= 1'b0;
      respawn <= 1'b0;
      coll_q  <= 1'b0;
      high    <= '0;
    end else begin
      state   <= state_nxt;
      lives   <= lives_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed_nxt;
      respawn <= respawn_nxt;
      coll_q  <= bus.i_Has_Collided;
      if (clamped > high) high <= clamped;
    end
  end

  always_comb begin
    state_nxt   = state;
    lives_nxt   = lives;
    cnt_nxt     = cnt;
    armed_nxt   = armed;
    respawn_nxt = 1'b0;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (armed && bus.i_Start) begin
          state_nxt   = RUNNING;
          lives_nxt   = LIVES_INI;
          respawn_nxt = 1'b1;
          armed_nxt   = 1'b0;
        end else if (!bus.i_Start) begin
          armed_nxt   = 1'b1;
        end
      end
      RUNNING: begin
        // collision edge takes priority; a coincident level-up is dropped
        if (coll_edge) begin
          state_nxt = DYING;
          lives_nxt = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
          cnt_nxt   = '0;
        end else if (bus.i_Level_Up) begin
          lives_nxt = (lives < LIVES_MAX) ? lives + 2'd1 : LIVES_MAX;
        end
      end
      DYING: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (lives != 2'd0) begin
            state_nxt   = RUNNING;
            respawn_nxt = 1'b1;
          end else begin
            state_nxt = GAME_OVER;
            armed_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_Game_Active  = (state == RUNNING);
  assign bus.o_Game_Over    = (state == GAME_OVER);
  assign bus.o_Frog_Respawn = respawn;
  assign bus.o_Lives        = lives;
  assign bus.o_High_Score   = high;
endmodule

// File: tb/tb_game_session_controller.sv
// Directed bench for game_session_controller with a short death freeze.
module tb_game_session_controller;
  localparam int FREEZE = 4;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  game_session_if bus();

  game_session_controller #(
    .c_LIVES_INI(3), .c_LIVES_MAX(3),
    .c_DEATH_FREEZE_CYCLES(FREEZE), .c_SCORE_MAX(99)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .bus  (bus.slave)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int act, input int rsp,
                           input int lives, input int go);
    chk({tag, ".active"},  int'(bus.o_Game_Active),  act);
    chk({tag, ".respawn"}, int'(bus.o_Frog_Respawn), rsp);
    chk({tag, ".lives"},   int'(bus.o_Lives),        lives);
    chk({tag, ".over"},    int'(bus.o_Game_Over),    go);
  endtask

  // one-cycle collision pulse, then ride out the freeze; returns after exit edge
  task automatic die(input int lives_after, input bit to_over);
    bus.i_Has_Collided = 1'b1;
    tick();
    bus.i_Has_Collided = 1'b0;
    chk_state("die.enter", 0, 0, lives_after, 0);
    repeat (FREEZE - 1) begin
      tick();
      chk("die.frozen", int'(bus.o_Game_Active), 0);
    end
    tick();
    if (to_over) chk_state("die.over", 0, 0, 0, 1);
    else         chk_state("die.respawn", 1, 1, lives_after, 0);
  endtask

  initial begin
    bus.i_Start = 1'b0;
    bus.i_Has_Collided = 1'b0;
    bus.i_Level_Up = 1'b0;
    bus.i_Score = 7'd0;
    tick();
    chk_state("reset", 0, 0, 3, 0);
    chk("reset.high", int'(bus.o_High_Score), 0);
    i_Rst = 1'b0;

    // basic start
    tick(); tick();
    chk("idle.active", int'(bus.o_Game_Active), 0);
    bus.i_Start = 1'b1;
    tick();
    chk_state("start", 1, 1, 3, 0);
    tick();
    chk("start.pulse1", int'(bus.o_Frog_Respawn), 0);

    // level-up at ceiling
    bus.i_Level_Up = 1'b1; tick(); bus.i_Level_Up = 1'b0;
    chk("lvl.sat", int'(bus.o_Lives), 3);

    // long collision: one death only
    bus.i_Has_Collided = 1'b1;
    tick();
    chk_state("long.enter", 0, 0, 2, 0);
    for (int i = 0; i < FREEZE - 1; i++) begin
      tick();
      chk("long.frozen", int'(bus.o_Game_Active), 0);
    end
    tick();
    chk_state("long.respawn", 1, 1, 2, 0);
    repeat (5) tick();
    chk_state("long.held", 1, 0, 2, 0);
    bus.i_Has_Collided = 1'b0;
    tick();

    // bonus life after death
    bus.i_Level_Up = 1'b1; tick(); bus.i_Level_Up = 1'b0;
    chk("lvl.inc", int'(bus.o_Lives), 3);

    // collision and level-up together
    bus.i_Has_Collided = 1'b1; bus.i_Level_Up = 1'b1;
    tick();
    bus.i_Has_Collided = 1'b0; bus.i_Level_Up = 1'b0;
    chk_state("prio", 0, 0, 2, 0);
    repeat (FREEZE) tick();
    chk_state("prio.back", 1, 1, 2, 0);

    // high score: clamp and one-cycle latency
    bus.i_Score = 7'd5;   tick(); chk("hs.5", int'(bus.o_High_Score), 5);
    bus.i_Score = 7'd12;  tick(); chk("hs.12", int'(bus.o_High_Score), 12);
    bus.i_Score = 7'd3;   tick(); chk("hs.3", int'(bus.o_High_Score), 12);
    bus.i_Score = 7'd120; #2; chk("hs.lat", int'(bus.o_High_Score), 12);
    tick(); chk("hs.120", int'(bus.o_High_Score), 99);
    bus.i_Score = 7'd0;

    // game over with start held throughout
    bus.i_Level_Up = 1'b1; tick(); bus.i_Level_Up = 1'b0;
    chk("go.refill", int'(bus.o_Lives), 3);
    tick();
    die(2, 1'b0);
    tick();
    die(1, 1'b0);
    tick();
    die(0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state("go.hold", 0, 0, 0, 1);
    end
    bus.i_Start = 1'b0; tick();
    chk("go.armwait", int'(bus.o_Game_Over), 1);
    bus.i_Start = 1'b1; tick();
    chk_state("go.restart", 1, 1, 3, 0);
    chk("go.high", int'(bus.o_High_Score), 99);

    // async reset mid-DYING
    bus.i_Has_Collided = 1'b1; tick(); bus.i_Has_Collided = 1'b0;
    chk_state("ar.dying", 0, 0, 2, 0);
    #2 i_Rst = 1'b1;
    #1;
    chk_state("ar.reset", 0, 0, 3, 0);
    chk("ar.high", int'(bus.o_High_Score), 0);
    #2 i_Rst = 1'b0;
    for (int i = 0; i < FREEZE + 2; i++) begin
      tick();
      chk_state("ar.idle", 0, 0, 3, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
